gaussian_sched: RTL and testbench

// Round-robin scheduler sharing one gaussian noise generator among N_REQ requesters.

---
 rtl/gaussian_sched.sv | 214 +++++++++++++++++++++
 tb/tb_gaussian_sched.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_sched.sv
// gaussian_sched: round-robin scheduler that shares one gaussian noise
// generator among N_REQ requesters. A granted burst drives the generator
// clock enable once per sample; each issued sample's owner and end-of-burst
// flag go into a tag FIFO, and each generator output is paired with its tag
// and written to a first-word-fall-through output FIFO. Issue is gated by a
// credit so every sample in flight always has an output slot waiting for it.
//
// Handshake: a sample moves to the consumer on any cycle where smp_valid and
// smp_ready are both high; smp_valid never waits for smp_ready and smp_*
// hold steady while smp_valid is high and smp_ready is low. Requests follow
// the same rule: req_valid[i] is held until the one-cycle req_ready[i] pulse.
module gaussian_sched #(
  parameter int N_REQ      = 4,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  output logic [N_REQ-1:0]         req_ready,
  output logic                     gen_ce,
  input  logic                     gen_valid,
  input  logic [15:0]              gen_data,
  output logic                     smp_valid,
  input  logic                     smp_ready,
  output logic [15:0]              smp_data,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] smp_id,
  output logic                     smp_last,
  output logic                     busy,
  output logic                     err_orphan
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = ID_W + 1;
  localparam int OUT_W = ID_W + 1 + 16;
  localparam int REM_W = LEN_W + 1;

  // A zero length field stands for the largest burst, 2^LEN_W samples.
  localparam logic [REM_W-1:0] REM_MAX = REM_W'(1) << LEN_W;
  localparam logic [CNT_W:0]   OCC_MAX = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t             state;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    owner;
  logic [REM_W-1:0]   remaining;

  // Round-robin search result
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_id;
  logic [LEN_W-1:0]   gnt_len;

  // Tag FIFO: {owner, last} for every sample issued to the generator
  logic [TAG_W-1:0]   tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   tag_wr_ptr;
  logic [PTR_W-1:0]   tag_rd_ptr;
  logic [CNT_W-1:0]   tag_cnt;

  // Output FIFO: {owner, last, data} waiting for the consumer
  logic [OUT_W-1:0]   out_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   out_wr_ptr;
  logic [PTR_W-1:0]   out_rd_ptr;
  logic [CNT_W-1:0]   out_cnt;

  logic [CNT_W:0]     occupancy;
  logic               can_issue;
  logic               tag_push;
  logic               tag_pop;
  logic               orphan;
  logic               out_push;
  logic               out_pop;
  logic [TAG_W-1:0]   tag_head;
  logic [OUT_W-1:0]   out_head;

  // Find the first requester at or after the round-robin pointer
  always_comb begin
    int idx;
    gnt_found = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    // Walk from the farthest candidate back to the pointer so the nearest
    // valid requester is the one left standing.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
    gnt_len = req_len[int'(gnt_id)*LEN_W +: LEN_W];
  end

  // Credit and FIFO control strobes
  always_comb begin
    occupancy = {1'b0, tag_cnt} + {1'b0, out_cnt};
    can_issue = (occupancy < OCC_MAX);
    tag_push  = (state == ISSUE) && can_issue;
    tag_pop   = gen_valid && (tag_cnt != '0);
    orphan    = gen_valid && (tag_cnt == '0);
    out_pop   = smp_valid && smp_ready;
    // The credit already guarantees room; the full check only protects the
    // FIFO if the generator breaks its one-output-per-enable contract.
    out_push  = tag_pop && ((out_cnt != CNT_FULL) || out_pop);
    tag_head  = tag_mem[tag_rd_ptr];
    out_head  = out_mem[out_rd_ptr];
  end

  // Scheduler FSM: grant in IDLE, issue one sample per credited cycle in ISSUE
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      remaining <= '0;
      req_ready <= '0;
      gen_ce    <= 1'b0;
    end else begin
      req_ready <= '0;
      gen_ce    <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            req_ready <= N_REQ'(1) << gnt_id;
            remaining <= (gnt_len == '0) ? REM_MAX : {1'b0, gnt_len};
            owner     <= gnt_id;
            rr_ptr    <= (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (can_issue) begin
            gen_ce    <= 1'b1;
            remaining <= remaining - REM_W'(1);
            if (remaining == REM_W'(1)) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO storage; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (tag_push) begin
      tag_mem[tag_wr_ptr] <= {owner, (remaining == REM_W'(1))};
    end
    if (out_push) begin
      out_mem[out_wr_ptr] <= {tag_head, gen_data};
    end
  end

  // Tag FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
      tag_cnt    <= '0;
    end else begin
      if (tag_push) tag_wr_ptr <= tag_wr_ptr + PTR_W'(1);
      if (tag_pop)  tag_rd_ptr <= tag_rd_ptr + PTR_W'(1);
      case ({tag_push, tag_pop})
        2'b10:   tag_cnt <= tag_cnt + CNT_W'(1);
        2'b01:   tag_cnt <= tag_cnt - CNT_W'(1);
        default: tag_cnt <= tag_cnt;
      endcase
    end
  end

  // Output FIFO pointers and occupancy; push+pop when full keeps the count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_wr_ptr <= '0;
      out_rd_ptr <= '0;
      out_cnt    <= '0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + PTR_W'(1);
      if (out_pop)  out_rd_ptr <= out_rd_ptr + PTR_W'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + CNT_W'(1);
        2'b01:   out_cnt <= out_cnt - CNT_W'(1);
        default: out_cnt <= out_cnt;
      endcase
    end
  end

  // Sticky orphan flag: a generator output arrived with no tag to own it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_orphan <= 1'b0;
    end else if (orphan) begin
      err_orphan <= 1'b1;
    end
  end

  // Head of the output FIFO, held at zero while empty
  always_comb begin
    smp_valid = (out_cnt != '0);
    smp_data  = smp_valid ? out_head[15:0] : 16'h0000;
    smp_last  = smp_valid ? out_head[16] : 1'b0;
    smp_id    = smp_valid ? out_head[OUT_W-1:17] : '0;
    busy      = (state != IDLE) || (tag_cnt != '0) || (out_cnt != '0);
  end

endmodule

// File: tb/tb_gaussian_sched.sv
// Bench for gaussian_sched. A small gaussian stand-in answers every enable
// one cycle later with a known data sequence. The model holds the expected
// grant order and expands each burst into its expected {id, last} tags;
// each generator output is paired with the next tag to form the expected
// sample stream that every consumer transfer is compared against.
module tb_gaussian_sched;

  localparam int N_REQ = 4;
  localparam int LEN_W = 8;
  localparam int DEPTH = 16;

  logic                   clk;
  logic                   rstn;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*LEN_W-1:0] req_len;
  logic [N_REQ-1:0]       req_ready;
  logic                   gen_ce;
  logic                   gen_valid;
  logic [15:0]            gen_data;
  logic                   smp_valid;
  logic                   smp_ready;
  logic [15:0]            smp_data;
  logic [1:0]             smp_id;
  logic                   smp_last;
  logic                   busy;
  logic                   err_orphan;

  gaussian_sched #(.N_REQ(N_REQ), .LEN_W(LEN_W), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_len(req_len), .req_ready(req_ready),
    .gen_ce(gen_ce), .gen_valid(gen_valid), .gen_data(gen_data),
    .smp_valid(smp_valid), .smp_ready(smp_ready), .smp_data(smp_data),
    .smp_id(smp_id), .smp_last(smp_last),
    .busy(busy), .err_orphan(err_orphan)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard state ----------------
  logic [18:0] exp_q[$];     // {id, last, data} in consumer order
  logic [2:0]  tag_q[$];     // {id, last} in issue order
  int          grant_q[$];   // expected grant order
  int          req_cnt[N_REQ];
  logic [7:0]  len_cfg[N_REQ];
  int          sid_log[$];
  int          slast_log[$];
  int          checks;
  int          errors;
  int          issued;
  int          xfers;
  logic        force_orphan;
  logic        pend_valid;
  logic [18:0] pend_smp;
  logic [15:0] gen_seq;
  logic        prev_stall;
  logic [18:0] prev_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    tag_q.delete();
    grant_q.delete();
    sid_log.delete();
    slast_log.delete();
    for (int i = 0; i < N_REQ; i++) req_cnt[i] = 0;
    req_valid    = '0;
    gen_valid    = 1'b0;
    pend_valid   = 1'b0;
    force_orphan = 1'b0;
    issued       = 0;
    xfers        = 0;
  endtask

  // Queue one burst: expected grant plus its expanded tag list
  task automatic start_burst(input int id, input int len);
    int n;
    n = (len == 0) ? 256 : len;
    len_cfg[id] = 8'(len);
    req_cnt[id]++;
    grant_q.push_back(id);
    for (int k = 0; k < n; k++) tag_q.push_back({2'(id), (k == n - 1)});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready), 0);
    chk({tag, "_gen_ce"},     32'(gen_ce), 0);
    chk({tag, "_smp_valid"},  32'(smp_valid), 0);
    chk({tag, "_smp_data"},   32'(smp_data), 0);
    chk({tag, "_smp_id"},     32'(smp_id), 0);
    chk({tag, "_smp_last"},   32'(smp_last), 0);
    chk({tag, "_busy"},       32'(busy), 0);
    chk({tag, "_err_orphan"}, 32'(err_orphan), 0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Wait for the scheduler and the model to drain, bounded
  task automatic wait_done(input string name, input int bound);
    int n;
    n = 0;
    while (n < bound && (busy || exp_q.size() != 0 || tag_q.size() != 0)) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drain_timeout"}, 32'(n >= bound), 0);
    chk({name, "_busy_low"}, 32'(busy), 0);
  endtask

  // ---------------- drivers: generator stand-in and requesters ----------------
  // Acts 1ns after each rising edge; gen_ce seen here is this cycle's enable.
  always @(posedge clk) begin
    #1;
    if (!rstn) begin
      gen_valid  = 1'b0;
      pend_valid = 1'b0;
    end else begin
      gen_valid = pend_valid | force_orphan;
      gen_data  = force_orphan ? 16'hdead : pend_smp[15:0];
      if (pend_valid) exp_q.push_back(pend_smp);
      pend_valid = gen_ce;
      if (gen_ce) begin
        issued++;
        if (tag_q.size() == 0) begin
          chk("extra_gen_ce", 1, 0);
          pend_valid = 1'b0;
        end else begin
          pend_smp = {tag_q.pop_front(), 16'(gen_seq * 16'd37 + 16'd11)};
          gen_seq  = gen_seq + 16'd1;
        end
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && req_cnt[i] > 0) req_cnt[i]--;
        req_valid[i] = (req_cnt[i] > 0);
        req_len[i*LEN_W +: LEN_W] = len_cfg[i];
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (req_ready != '0) begin
        if (grant_q.size() == 0) chk("unexpected_grant", 32'(req_ready), 0);
        else chk("grant", 32'(req_ready), 32'(1) << grant_q.pop_front());
      end
      if (prev_stall) chk("stall_stable", 32'({smp_id, smp_last, smp_data}), 32'(prev_out));
      if (smp_valid && smp_ready) begin
        xfers++;
        sid_log.push_back(int'(smp_id));
        slast_log.push_back(int'(smp_last));
        if (exp_q.size() == 0) chk("unexpected_sample", 32'({smp_id, smp_last, smp_data}), 0);
        else chk("sample", 32'({smp_id, smp_last, smp_data}), 32'(exp_q.pop_front()));
      end
      prev_stall = smp_valid && !smp_ready;
      prev_out   = {smp_id, smp_last, smp_data};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    int exp_ids[10];
    int n;
    checks  = 0;
    errors  = 0;
    gen_seq = 16'd0;
    req_len = '0;
    for (int i = 0; i < N_REQ; i++) len_cfg[i] = 8'd0;
    smp_ready = 1'b1;
    gen_data  = 16'h0000;
    prev_stall = 1'b0;
    prev_out   = '0;
    rstn = 1'b0;
    clear_model();
    #1;
    chk_reset_vals("reset");
    do_reset();

    // 1. single requester 0, len 3
    @(posedge clk); #2;
    start_burst(0, 3);
    n = 0;
    while (n < 10 && req_ready == '0) begin @(negedge clk); n++; end
    chk("t1_grant_seen", 32'(n < 10), 1);
    @(negedge clk);
    chk("t1_first_ce_latency", 32'(gen_ce), 1);
    wait_done("t1", 100);
    chk("t1_issued", 32'(issued), 3);
    chk("t1_xfers", 32'(xfers), 3);
    if (sid_log.size() == 3) begin
      chk("t1_id0", 32'(sid_log[0] + sid_log[1] + sid_log[2]), 0);
      chk("t1_last_pattern", 32'({slast_log[0][0], slast_log[1][0], slast_log[2][0]}), 32'b001);
    end else chk("t1_log_size", 32'(sid_log.size()), 3);

    // 2. all four requesting len 2; requester 0 asks twice
    do_reset();
    @(posedge clk); #2;
    start_burst(0, 2); start_burst(1, 2); start_burst(2, 2); start_burst(3, 2); start_burst(0, 2);
    wait_done("t2", 300);
    chk("t2_xfers", 32'(xfers), 10);
    exp_ids = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    if (sid_log.size() == 10) begin
      for (int i = 0; i < 10; i++) chk("t2_id_seq", 32'(sid_log[i]), 32'(exp_ids[i]));
    end else chk("t2_log_size", 32'(sid_log.size()), 10);

    // 3. consumer stalled, len 0 (256 samples): issue stops at the credit
    do_reset();
    @(posedge clk); #2;
    smp_ready = 1'b0;
    start_burst(1, 0);
    repeat (60) @(negedge clk);
    chk("t3_stall_issued", 32'(issued), 16);
    chk("t3_smp_valid", 32'(smp_valid), 1);
    chk("t3_smp_id", 32'(smp_id), 1);
    chk("t3_first_data", 32'(smp_data), 32'(16'(gen_seq - 16'd16) * 16'd37 + 16'd11));
    chk("t3_gen_ce_off", 32'(gen_ce), 0);
    @(posedge clk); #2;
    smp_ready = 1'b1;
    wait_done("t3", 2000);
    chk("t3_xfers", 32'(xfers), 256);
    n = 0;
    foreach (slast_log[i]) n += slast_log[i];
    chk("t3_last_count", 32'(n), 1);
    if (slast_log.size() == 256) chk("t3_last_pos", 32'(slast_log[255]), 1);

    // 4. consumer ready toggles every cycle, len 40
    do_reset();
    @(posedge clk); #2;
    start_burst(2, 40);
    n = 0;
    while (n < 600 && (busy || exp_q.size() != 0 || tag_q.size() != 0 || n < 3)) begin
      @(posedge clk); #2;
      smp_ready = ~smp_ready;
      n++;
    end
    chk("t4_timeout", 32'(n >= 600), 0);
    smp_ready = 1'b1;
    chk("t4_xfers", 32'(xfers), 40);

    // 5. generator output with nothing issued
    do_reset();
    @(posedge clk); #2;
    force_orphan = 1'b1;
    @(posedge clk); #2;
    force_orphan = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t5_err_orphan", 32'(err_orphan), 1);
    chk("t5_smp_valid", 32'(smp_valid), 0);
    chk("t5_busy", 32'(busy), 0);
    repeat (5) @(negedge clk);
    chk("t5_err_sticky", 32'(err_orphan), 1);

    // 6. asynchronous reset in the middle of a burst, then a clean burst
    @(posedge clk); #2;
    start_burst(3, 20);
    repeat (8) @(negedge clk);
    chk("t6_mid_burst_busy", 32'(busy), 1);
    #2;
    rstn = 1'b0;
    clear_model();
    #1;
    chk_reset_vals("t6_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk); #2;
    start_burst(2, 5);
    wait_done("t6", 200);
    chk("t6_xfers", 32'(xfers), 5);
    if (sid_log.size() == 5) begin
      chk("t6_id", 32'(sid_log[0] + sid_log[4]), 4);
      chk("t6_last", 32'(slast_log[4]), 1);
    end else chk("t6_log_size", 32'(sid_log.size()), 5);
    chk("t6_err_clear", 32'(err_orphan), 0);

    chk("end_exp_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
